axi_rd_arb: RTL and testbench
=============================

AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 Parameter OST_MAX, default 8: maximum outstanding read bursts per requester, legal range 1..15.
REQ-002 clk  in  1  single clock; all flops rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 reqN_arvld  in  1  read request from requester N, N in {0,1}.
REQ-005 reqN_araddr[9:0], reqN_arlen[7:0], reqN_arsize[2:0], reqN_arburst[1:0], reqN_arstr[2:0], reqN_sram_addr[11:0]  in  request payload; held stable while reqN_arvld=1 and reqN_arrdy=0.
REQ-006 reqN_arrdy  out  1  request accepted this cycle.
REQ-007 lsu_axi_arvld, lsu_axi_arid[7:0], lsu_axi_araddr[9:0], lsu_axi_arlen[7:0], lsu_axi_arsize[2:0], lsu_axi_arburst[1:0], lsu_axi_arstr[2:0], lsu_axi_sram_addr[11:0]  out  registered request toward the AXI read interface.
REQ-008 axi_lsu_arrdy  in  1  downstream request ready.
REQ-009 axi_lsu_rid[7:0], axi_lsu_rdata[63:0], axi_lsu_rresp[1:0], axi_lsu_rlast, axi_lsu_rvld  in  response from the AXI read interface.
REQ-010 lsu_axi_rrdy  out  1  response ready toward the AXI read interface.
REQ-011 reqN_rvld, reqN_rdata[63:0], reqN_rresp[1:0], reqN_rlast  out  routed response; reqN_rrdy  in  1.

Function
REQ-012 FSM states: IDLE, ISSUE.
REQ-013 Requester N is eligible when reqN_arvld=1 and ost_cntN < OST_MAX.
REQ-014 IDLE with at least one eligible requester: grant, pulse reqN_arrdy=1 for that one cycle, load its payload into the output registers, go to ISSUE.
REQ-015 Both eligible: grant the requester that is not last_grant; last_grant updates on every grant; after reset requester 0 wins the first tie.
REQ-016 ISSUE: lsu_axi_arvld=1, outputs held constant; when axi_lsu_arrdy=1, go to IDLE next cycle.
REQ-017 Minimum spacing between grants is 2 cycles; no grant is made in ISSUE.
REQ-018 lsu_axi_arid = {granted index, seqN[6:0]}; seqN increments by 1 per grant to N and wraps 127->0.
REQ-019 ost_cntN: +1 on grant to N; -1 on axi_lsu_rvld & lsu_axi_rrdy & axi_lsu_rlast with axi_lsu_rid[7]=N; both in one cycle leaves it unchanged.
REQ-020 Response routing is combinational: reqN_rvld = axi_lsu_rvld & (axi_lsu_rid[7]==N); data, resp and last fan out to both requesters; lsu_axi_rrdy = reqM_rrdy, where M = axi_lsu_rid[7].
REQ-021 A decrement with ost_cntN=0 is an error: the counter saturates at 0 and sticky flag err_underflow (internal, observable) is set.
REQ-022 reqN_arrdy is never asserted while ost_cntN = OST_MAX.

Reset
REQ-023 rst_n low forces, asynchronously: FSM=IDLE, lsu_axi_arvld=0, all lsu_axi_* payload=0, reqN_arrdy=0, seqN=0, ost_cntN=0, last_grant=1, err_underflow=0.
REQ-024 Reset asserted mid-ISSUE drops the pending request; no completion is expected.

Verification
REQ-025 Only req0 requests, araddr=0x040, arlen=3, axi_lsu_arrdy=1: req0_arrdy pulses at cycle 1; lsu_axi_arvld=1 at cycle 2 with arid=0x00 and araddr=0x040; it is back to 0 at cycle 3.
REQ-026 Both requesters request continuously, arrdy=1: grants alternate 0,1,0,1; arids are 0x00, 0x80, 0x01, 0x81.
REQ-027 req1 requests with no responses returned, OST_MAX=8: exactly 8 grants, then req1_arrdy stays 0; one rlast response with rid=0x80 re-enables a single grant.
REQ-028 Response rid=0x81, rlast=1, req1_rrdy=0, req0_rrdy=1: req1_rvld=1, req0_rvld=0, lsu_axi_rrdy=0, counter unchanged until req1_rrdy=1.
REQ-029 axi_lsu_arrdy=0 for 5 cycles during ISSUE: lsu_axi_* stays stable and no reqN_arrdy pulses; rst_n pulsed low in cycle 3 clears lsu_axi_arvld immediately.

Source files
------------

// File: rtl/axi_rd_arb_if.sv
// rtl/axi_rd_arb_if.sv - request, AXI read and routed-response signals of the read arbiter
// slave is the arbiter's view; master is the view of the requesters and AXI read port.
interface axi_rd_arb_if;
  logic        req0_arvld,     req1_arvld;
  logic [9:0]  req0_araddr,    req1_araddr;
  logic [7:0]  req0_arlen,     req1_arlen;
  logic [2:0]  req0_arsize,    req1_arsize;
  logic [1:0]  req0_arburst,   req1_arburst;
  logic [2:0]  req0_arstr,     req1_arstr;
  logic [11:0] req0_sram_addr, req1_sram_addr;
  logic        req0_arrdy,     req1_arrdy;

  logic        lsu_axi_arvld;
  logic [7:0]  lsu_axi_arid;
  logic [9:0]  lsu_axi_araddr;
  logic [7:0]  lsu_axi_arlen;
  logic [2:0]  lsu_axi_arsize;
  logic [1:0]  lsu_axi_arburst;
  logic [2:0]  lsu_axi_arstr;
  logic [11:0] lsu_axi_sram_addr;
  logic        axi_lsu_arrdy;

  logic [7:0]  axi_lsu_rid;
  logic [63:0] axi_lsu_rdata;
  logic [1:0]  axi_lsu_rresp;
  logic        axi_lsu_rlast;
  logic        axi_lsu_rvld;
  logic        lsu_axi_rrdy;

  logic        req0_rvld,  req1_rvld;
  logic [63:0] req0_rdata, req1_rdata;
  logic [1:0]  req0_rresp, req1_rresp;
  logic        req0_rlast, req1_rlast;
  logic        req0_rrdy,  req1_rrdy;

  modport slave (
    input  req0_arvld, req0_araddr, req0_arlen, req0_arsize, req0_arburst, req0_arstr, req0_sram_addr,
    input  req1_arvld, req1_araddr, req1_arlen, req1_arsize, req1_arburst, req1_arstr, req1_sram_addr,
    output req0_arrdy, req1_arrdy,
    output lsu_axi_arvld, lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
    output lsu_axi_arburst, lsu_axi_arstr, lsu_axi_sram_addr,
    input  axi_lsu_arrdy,
    input  axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld,
    output lsu_axi_rrdy,
    output req0_rvld, req0_rdata, req0_rresp, req0_rlast,
    output req1_rvld, req1_rdata, req1_rresp, req1_rlast,
    input  req0_rrdy, req1_rrdy
  );

  modport master (
    output req0_arvld, req0_araddr, req0_arlen, req0_arsize, req0_arburst, req0_arstr, req0_sram_addr,
    output req1_arvld, req1_araddr, req1_arlen, req1_arsize, req1_arburst, req1_arstr, req1_sram_addr,
    input  req0_arrdy, req1_arrdy,
    input  lsu_axi_arvld, lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
    input  lsu_axi_arburst, lsu_axi_arstr, lsu_axi_sram_addr,
    output axi_lsu_arrdy,
    output axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld,
    input  lsu_axi_rrdy,
    input  req0_rvld, req0_rdata, req0_rresp, req0_rlast,
    input  req1_rvld, req1_rdata, req1_rresp, req1_rlast,
    output req0_rrdy, req1_rrdy
  );
endinterface

// File: rtl/axi_rd_arb.sv
// rtl/axi_rd_arb.sv - two-requester round-robin AXI read request arbiter with response routing
// Outstanding bursts are tracked per requester; rid[7] carries the requester index.
module axi_rd_arb #(
  parameter int OST_MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  axi_rd_arb_if.slave  bus,
  output logic         o_err_underflow
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  w_arvld, w_elig, w_gnt, w_dec;
  logic        w_gnt_any, w_gnt_idx, w_rsp_id, w_rrdy;
  logic        r_last_grant, r_err;
  logic [6:0]  r_seq [2];
  logic [3:0]  r_ost [2];

  logic [7:0]  r_arid;
  logic [9:0]  r_araddr;
  logic [7:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic [1:0]  r_arburst;
  logic [2:0]  r_arstr;
  logic [11:0] r_sram_addr;

  assign w_arvld = {bus.req1_arvld, bus.req0_arvld};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_elig[i] = w_arvld[i] && (r_ost[i] < 4'(OST_MAX));
    end
  end

  // On a tie the requester that did not win last time is served.
  assign w_gnt_any = (r_state == S_IDLE) && (|w_elig);
  assign w_gnt_idx = (&w_elig) ? ~r_last_grant : w_elig[1];
  assign w_gnt     = w_gnt_any ? (w_gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_any)         w_state_nxt = S_ISSUE;
      S_ISSUE: if (bus.axi_lsu_arrdy) w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.lsu_axi_arvld = (r_state == S_ISSUE);
    bus.req0_arrdy    = w_gnt[0] & rst_n;
    bus.req1_arrdy    = w_gnt[1] & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arid      <= '0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arsize    <= '0;
      r_arburst   <= '0;
      r_arstr     <= '0;
      r_sram_addr <= '0;
    end else if (w_gnt_any) begin
      r_arid      <= {w_gnt_idx, r_seq[w_gnt_idx]};
      r_araddr    <= w_gnt_idx ? bus.req1_araddr    : bus.req0_araddr;
      r_arlen     <= w_gnt_idx ? bus.req1_arlen     : bus.req0_arlen;
      r_arsize    <= w_gnt_idx ? bus.req1_arsize    : bus.req0_arsize;
      r_arburst   <= w_gnt_idx ? bus.req1_arburst   : bus.req0_arburst;
      r_arstr     <= w_gnt_idx ? bus.req1_arstr     : bus.req0_arstr;
      r_sram_addr <= w_gnt_idx ? bus.req1_sram_addr : bus.req0_sram_addr;
    end
  end

  assign bus.lsu_axi_arid      = r_arid;
  assign bus.lsu_axi_araddr    = r_araddr;
  assign bus.lsu_axi_arlen     = r_arlen;
  assign bus.lsu_axi_arsize    = r_arsize;
  assign bus.lsu_axi_arburst   = r_arburst;
  assign bus.lsu_axi_arstr     = r_arstr;
  assign bus.lsu_axi_sram_addr = r_sram_addr;

  assign w_rsp_id = bus.axi_lsu_rid[7];
  assign w_rrdy   = w_rsp_id ? bus.req1_rrdy : bus.req0_rrdy;
  assign w_dec    = {2{bus.axi_lsu_rvld & w_rrdy & bus.axi_lsu_rlast}} & {w_rsp_id, ~w_rsp_id};

  assign bus.lsu_axi_rrdy = w_rrdy;
  assign bus.req0_rvld    = bus.axi_lsu_rvld & ~w_rsp_id;
  assign bus.req1_rvld    = bus.axi_lsu_rvld &  w_rsp_id;
  assign bus.req0_rdata   = bus.axi_lsu_rdata;
  assign bus.req1_rdata   = bus.axi_lsu_rdata;
  assign bus.req0_rresp   = bus.axi_lsu_rresp;
  assign bus.req1_rresp   = bus.axi_lsu_rresp;
  assign bus.req0_rlast   = bus.axi_lsu_rlast;
  assign bus.req1_rlast   = bus.axi_lsu_rlast;

  // A completion with nothing outstanding saturates at zero and latches the error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_err        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_seq[i] <= '0;
        r_ost[i] <= '0;
      end
    end else begin
      if (w_gnt_any) r_last_grant <= w_gnt_idx;
      for (int i = 0; i < 2; i++) begin
        if (w_gnt[i]) r_seq[i] <= r_seq[i] + 7'd1;
        case ({w_gnt[i], w_dec[i]})
          2'b10:   r_ost[i] <= r_ost[i] + 4'd1;
          2'b01: begin
            if (r_ost[i] != 4'd0) r_ost[i] <= r_ost[i] - 4'd1;
            else                  r_err    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_err_underflow = r_err;

endmodule

// File: tb/tb_axi_rd_arb.sv
// tb/tb_axi_rd_arb.sv - directed self-checking bench for axi_rd_arb
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_axi_rd_arb;

  logic clk;
  logic rst_n;
  logic err;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses;

  axi_rd_arb_if bus ();

  axi_rd_arb #(.OST_MAX(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .o_err_underflow (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req0_arvld = 0; bus.req0_araddr = 0; bus.req0_arlen = 0; bus.req0_arsize = 0;
    bus.req0_arburst = 0; bus.req0_arstr = 0; bus.req0_sram_addr = 0;
    bus.req1_arvld = 0; bus.req1_araddr = 0; bus.req1_arlen = 0; bus.req1_arsize = 0;
    bus.req1_arburst = 0; bus.req1_arstr = 0; bus.req1_sram_addr = 0;
    bus.axi_lsu_arrdy = 0; bus.axi_lsu_rid = 0; bus.axi_lsu_rdata = 0; bus.axi_lsu_rresp = 0;
    bus.axi_lsu_rlast = 0; bus.axi_lsu_rvld = 0; bus.req0_rrdy = 0; bus.req1_rrdy = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic       exp_idx [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] exp_id  [4] = '{8'h00, 8'h80, 8'h01, 8'h81};

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("rst_arvld", bus.lsu_axi_arvld, 0);
    chk("rst_arid", bus.lsu_axi_arid, 0);
    chk("rst_araddr", bus.lsu_axi_araddr, 0);
    chk("rst_sram", bus.lsu_axi_sram_addr, 0);
    chk("rst_err", err, 0);
    bus.req0_arvld = 1;
    bus.req1_arvld = 1;
    #1;
    chk("rst_arrdy0", bus.req0_arrdy, 0);
    chk("rst_arrdy1", bus.req1_arrdy, 0);
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single request from req0
    bus.req0_arvld = 1; bus.req0_araddr = 10'h040; bus.req0_arlen = 8'd3; bus.req0_arsize = 3'd3;
    bus.req0_arburst = 2'd1; bus.req0_arstr = 3'd2; bus.req0_sram_addr = 12'h123;
    bus.axi_lsu_arrdy = 1;
    #1;
    chk("t1_arrdy0", bus.req0_arrdy, 1);
    chk("t1_arrdy1", bus.req1_arrdy, 0);
    chk("t1_arvld_c1", bus.lsu_axi_arvld, 0);
    @(negedge clk);
    bus.req0_arvld = 0;
    #1;
    chk("t1_arvld_c2", bus.lsu_axi_arvld, 1);
    chk("t1_arid", bus.lsu_axi_arid, 8'h00);
    chk("t1_araddr", bus.lsu_axi_araddr, 10'h040);
    chk("t1_arlen", bus.lsu_axi_arlen, 8'd3);
    chk("t1_arsize", bus.lsu_axi_arsize, 3'd3);
    chk("t1_arburst", bus.lsu_axi_arburst, 2'd1);
    chk("t1_arstr", bus.lsu_axi_arstr, 3'd2);
    chk("t1_sram", bus.lsu_axi_sram_addr, 12'h123);
    chk("t1_arrdy0_c2", bus.req0_arrdy, 0);
    @(negedge clk);
    #1;
    chk("t1_arvld_c3", bus.lsu_axi_arvld, 0);

    // Both requesting continuously: alternate grants
    do_reset();
    bus.req0_arvld = 1; bus.req0_araddr = 10'h100;
    bus.req1_arvld = 1; bus.req1_araddr = 10'h200;
    bus.axi_lsu_arrdy = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_arrdy0", bus.req0_arrdy, !exp_idx[k]);
      chk("t2_arrdy1", bus.req1_arrdy, exp_idx[k]);
      @(negedge clk);
      #1;
      chk("t2_arvld", bus.lsu_axi_arvld, 1);
      chk("t2_arid", bus.lsu_axi_arid, exp_id[k]);
      chk("t2_araddr", bus.lsu_axi_araddr, exp_idx[k] ? 10'h200 : 10'h100);
      chk("t2_nogrant_issue", bus.req0_arrdy | bus.req1_arrdy, 0);
      @(negedge clk);
    end
    bus.req0_arvld = 0;
    bus.req1_arvld = 0;

    // Outstanding limit on req1
    do_reset();
    bus.req1_arvld = 1; bus.req1_araddr = 10'h0AA;
    bus.axi_lsu_arrdy = 1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.req1_arrdy) pulses++;
      @(negedge clk);
    end
    chk("t3_grants", pulses, 8);
    #1;
    chk("t3_arrdy_full", bus.req1_arrdy, 0);
    chk("t3_arvld_idle", bus.lsu_axi_arvld, 0);
    bus.axi_lsu_rid = 8'h80; bus.axi_lsu_rlast = 1; bus.axi_lsu_rvld = 1;
    bus.axi_lsu_rdata = 64'hDEAD_BEEF_0123_4567; bus.axi_lsu_rresp = 2'b10;
    bus.req1_rrdy = 1;
    #1;
    chk("t3_rvld1", bus.req1_rvld, 1);
    chk("t3_rvld0", bus.req0_rvld, 0);
    chk("t3_rrdy", bus.lsu_axi_rrdy, 1);
    chk("t3_rdata1", bus.req1_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("t3_rdata0", bus.req0_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("t3_rresp0", bus.req0_rresp, 2'b10);
    chk("t3_rlast1", bus.req1_rlast, 1);
    chk("t3_arrdy_rsp", bus.req1_arrdy, 0);
    @(negedge clk);
    bus.axi_lsu_rvld = 0; bus.axi_lsu_rlast = 0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.req1_arrdy) pulses++;
      @(negedge clk);
    end
    chk("t3_regrant", pulses, 1);
    chk("t3_arid9", bus.lsu_axi_arid, 8'h88);

    // Response held back by req1_rrdy=0
    bus.axi_lsu_rid = 8'h81; bus.axi_lsu_rlast = 1; bus.axi_lsu_rvld = 1;
    bus.req1_rrdy = 0; bus.req0_rrdy = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_rvld1", bus.req1_rvld, 1);
      chk("t4_rvld0", bus.req0_rvld, 0);
      chk("t4_rrdy", bus.lsu_axi_rrdy, 0);
      chk("t4_arrdy_held", bus.req1_arrdy, 0);
      @(negedge clk);
    end
    bus.req1_rrdy = 1;
    #1;
    chk("t4_rrdy_go", bus.lsu_axi_rrdy, 1);
    @(negedge clk);
    bus.axi_lsu_rvld = 0; bus.axi_lsu_rlast = 0;
    #1;
    chk("t4_arrdy_freed", bus.req1_arrdy, 1);
    @(negedge clk);
    bus.req1_arvld = 0;

    // Completion for req0 with nothing outstanding
    repeat (2) @(negedge clk);
    #1;
    chk("t5_err_before", err, 0);
    bus.axi_lsu_rid = 8'h00; bus.axi_lsu_rlast = 1; bus.axi_lsu_rvld = 1; bus.req0_rrdy = 1;
    @(negedge clk);
    bus.axi_lsu_rvld = 0; bus.axi_lsu_rlast = 0;
    #1;
    chk("t5_err_after", err, 1);
    @(negedge clk);
    #1;
    chk("t5_err_sticky", err, 1);

    // Stalled ISSUE, then reset mid-ISSUE
    do_reset();
    #1;
    chk("t6_err_cleared", err, 0);
    bus.req0_arvld = 1; bus.req0_araddr = 10'h155; bus.req0_sram_addr = 12'hABC;
    bus.axi_lsu_arrdy = 0;
    #1;
    chk("t6_arrdy0", bus.req0_arrdy, 1);
    @(negedge clk);
    bus.req0_arvld = 0;
    bus.req1_arvld = 1; bus.req1_araddr = 10'h3FF;
    for (int c = 1; c <= 2; c++) begin
      #1;
      chk("t6_stall_arvld", bus.lsu_axi_arvld, 1);
      chk("t6_stall_araddr", bus.lsu_axi_araddr, 10'h155);
      chk("t6_stall_sram", bus.lsu_axi_sram_addr, 12'hABC);
      chk("t6_stall_arid", bus.lsu_axi_arid, 8'h00);
      chk("t6_stall_nogrant", bus.req0_arrdy | bus.req1_arrdy, 0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("t6_rst_arvld", bus.lsu_axi_arvld, 0);
    chk("t6_rst_araddr", bus.lsu_axi_araddr, 0);
    chk("t6_rst_arrdy1", bus.req1_arrdy, 0);
    bus.req1_arvld = 0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.axi_lsu_arrdy = 1;
    @(negedge clk);
    #1;
    chk("t6_dropped", bus.lsu_axi_arvld, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
